// File: rtl/mem_ctrl_pkg.sv
// Shared widths, state encodings and helpers for the cache-to-RAM byte controller.
package mem_ctrl_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 3;
    localparam int WAIT_W = 2;
    localparam logic [1:0] IO_HI = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic SRC_IC = 1'b0;
    localparam logic SRC_DC = 1'b1;

    // Anything other than 1 or 2 bytes is treated as a full word.
    function automatic logic [LEN_W-1:0] norm_len(input logic [LEN_W-1:0] len);
        return (len == LEN_W'(1) || len == LEN_W'(2)) ? len : LEN_W'(4);
    endfunction
endpackage

// File: rtl/mem_ctrl_if.sv
// Cache request/response and byte-wide RAM bus bundle for mem_ctrl.
interface mem_ctrl_if;
    import mem_ctrl_pkg::*;

    logic              iIC_en;
    logic [ADDR_W-1:0] iIC_pc;
    logic              oIC_done;
    logic [DATA_W-1:0] oIC_dt;
    logic              iDC_en;
    logic              iDC_ls;
    logic [ADDR_W-1:0] iDC_pc;
    logic [DATA_W-1:0] iDC_dt;
    logic [LEN_W-1:0]  iDC_len;
    logic              oDC_done;
    logic [DATA_W-1:0] oDC_dt;
    logic [WAIT_W-1:0] oWait;
    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;
    logic              io_buffer_full;

    // Controller side.
    modport slave (
        input  iIC_en, iIC_pc, iDC_en, iDC_ls, iDC_pc, iDC_dt, iDC_len, mem_din, io_buffer_full,
        output oIC_done, oIC_dt, oDC_done, oDC_dt, oWait, mem_dout, mem_a, mem_wr
    );

    // Caches and RAM side.
    modport master (
        output iIC_en, iIC_pc, iDC_en, iDC_ls, iDC_pc, iDC_dt, iDC_len, mem_din, io_buffer_full,
        input  oIC_done, oIC_dt, oDC_done, oDC_dt, oWait, mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_byte_seq.sv
// Byte sequencer: counter, address increment, lane select/assemble and IO store stall.
module mem_byte_seq
    import mem_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_a,
    input  logic [DATA_W-1:0] start_dt,
    input  logic [LEN_W-1:0]  start_len,
    input  logic              rd_act,
    input  logic              wr_act,
    input  logic [7:0]        mem_din,
    input  logic              io_full,
    output logic [ADDR_W-1:0] mem_a,
    output logic [7:0]        mem_dout,
    output logic              stall,
    output logic              last,
    output logic [DATA_W-1:0] data_nxt
);
    logic [ADDR_W-1:0] base_q, base_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              io_q, io_d;
    logic [1:0]        lane;

    always_comb begin
        base_d = base_q;
        data_d = data_q;
        cnt_d  = cnt_q;
        len_d  = len_q;
        io_d   = io_q;
        last   = 1'b0;
        lane   = cnt_q[1:0] - 2'd1;
        stall  = io_q & io_full;
        if (rdy) begin
            if (start) begin
                base_d = start_a;
                data_d = start_dt;
                cnt_d  = '0;
                len_d  = start_len;
                io_d   = (start_a[17:16] == IO_HI);
            end else if (rd_act) begin
                // RAM answers one cycle late, so cycle k captures byte k-1.
                if (cnt_q != '0) data_d = data_q | (DATA_W'(mem_din) << {lane, 3'b000});
                last  = (cnt_q == len_q);
                cnt_d = cnt_q + LEN_W'(1);
            end else if (wr_act && !stall) begin
                last  = (cnt_q == len_q - LEN_W'(1));
                cnt_d = cnt_q + LEN_W'(1);
            end
        end
    end

    // While frozen mid-read, present the previous address so the RAM keeps
    // returning the byte still owed to us when rdy comes back.
    assign mem_a    = base_q + ADDR_W'(cnt_q) - ADDR_W'(rd_act & ~rdy);
    assign mem_dout = 8'(data_q >> {cnt_q[1:0], 3'b000});
    assign data_nxt = data_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q <= '0;
            data_q <= '0;
            cnt_q  <= '0;
            len_q  <= '0;
            io_q   <= 1'b0;
        end else begin
            base_q <= base_d;
            data_q <= data_d;
            cnt_q  <= cnt_d;
            len_q  <= len_d;
            io_q   <= io_d;
        end
    end
endmodule

// File: rtl/mem_ctrl.sv
// Arbiter FSM between icache/dcache and the 8-bit RAM/IO bus; dcache wins ties.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       rdy,
    mem_ctrl_if.slave  bus
);
    state_e            state_q, state_d;
    logic              src_q, src_d;
    logic              ic_done_q, ic_done_d, dc_done_q, dc_done_d;
    logic [DATA_W-1:0] ic_dt_q, ic_dt_d, dc_dt_q, dc_dt_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    logic              start;
    logic [ADDR_W-1:0] st_a;
    logic [DATA_W-1:0] st_dt;
    logic [LEN_W-1:0]  st_len;
    logic              seq_stall, seq_last;
    logic [DATA_W-1:0] seq_data;

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        ic_done_d = ic_done_q;
        dc_done_d = dc_done_q;
        ic_dt_d   = ic_dt_q;
        dc_dt_d   = dc_dt_q;
        wait_d    = wait_q;
        start     = 1'b0;
        st_a      = bus.iDC_pc;
        st_dt     = '0;
        st_len    = LEN_W'(4);
        if (rdy) begin
            case (state_q)
                IDLE: begin
                    if (bus.iDC_en) begin
                        start   = 1'b1;
                        src_d   = SRC_DC;
                        st_dt   = bus.iDC_ls ? bus.iDC_dt : '0;
                        st_len  = norm_len(bus.iDC_len);
                        state_d = bus.iDC_ls ? WRITE : READ;
                        wait_d  = 2'b11;
                    end else if (bus.iIC_en) begin
                        start   = 1'b1;
                        src_d   = SRC_IC;
                        st_a    = bus.iIC_pc;
                        state_d = READ;
                        wait_d  = 2'b11;
                    end
                end
                READ, WRITE: begin
                    if (seq_last) begin
                        state_d = DONE;
                        if (src_q == SRC_DC) begin
                            dc_done_d = 1'b1;
                            dc_dt_d   = seq_data;
                        end else begin
                            ic_done_d = 1'b1;
                            ic_dt_d   = seq_data;
                        end
                    end
                end
                // Wait stays high through DONE so a cache reacting to done cannot re-issue early.
                DONE: begin
                    state_d   = IDLE;
                    ic_done_d = 1'b0;
                    dc_done_d = 1'b0;
                    wait_d    = 2'b00;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    mem_byte_seq u_seq (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .start    (start),
        .start_a  (st_a),
        .start_dt (st_dt),
        .start_len(st_len),
        .rd_act   (state_q == READ),
        .wr_act   (state_q == WRITE),
        .mem_din  (bus.mem_din),
        .io_full  (bus.io_buffer_full),
        .mem_a    (bus.mem_a),
        .mem_dout (bus.mem_dout),
        .stall    (seq_stall),
        .last     (seq_last),
        .data_nxt (seq_data)
    );

    assign bus.mem_wr   = (state_q == WRITE) & rdy & ~seq_stall;
    assign bus.oIC_done = ic_done_q;
    assign bus.oDC_done = dc_done_q;
    assign bus.oIC_dt   = ic_dt_q;
    assign bus.oDC_dt   = dc_dt_q;
    assign bus.oWait    = wait_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            src_q     <= SRC_IC;
            ic_done_q <= 1'b0;
            dc_done_q <= 1'b0;
            ic_dt_q   <= '0;
            dc_dt_q   <= '0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            ic_done_q <= ic_done_d;
            dc_done_q <= dc_done_d;
            ic_dt_q   <= ic_dt_d;
            dc_dt_q   <= dc_dt_d;
            wait_q    <= wait_d;
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: directed requests, byte-level RAM model, decoupled monitor.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    mem_ctrl_if bus();

    mem_ctrl dut (.clk(clk), .rst(rst), .rdy(rdy), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic        src;
        logic        chk_dt;
        logic [31:0] dt;
        int          lat;
    } exp_t;
    typedef struct {
        logic [31:0] a;
        logic [7:0]  b;
    } wr_t;

    exp_t exp_q[$];
    wr_t  wr_q[$];
    exp_t e;
    wr_t  w;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [7:0] ram [0:65535];

    // Registered-read RAM: data appears the cycle after the address.
    always @(posedge clk) begin
        bus.mem_din <= ram[bus.mem_a[15:0]];
        if (bus.mem_wr) ram[bus.mem_a[15:0]] = bus.mem_dout;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic void exp_done(input logic src, input logic chk_dt, input logic [31:0] dt, input int lat);
        exp_t x;
        x.src = src; x.chk_dt = chk_dt; x.dt = dt; x.lat = lat;
        exp_q.push_back(x);
    endfunction

    function automatic void exp_wr(input logic [31:0] a, input logic [7:0] b);
        wr_t x;
        x.a = a; x.b = b;
        wr_q.push_back(x);
    endfunction

    // Monitor: latency is counted from the first cycle oWait reads 11.
    int cyc = 0;
    int rise_cyc = 0;
    logic [1:0] wait_prev = 2'b00;
    always @(negedge clk) begin
        cyc++;
        if (bus.oWait == 2'b11 && wait_prev != 2'b11) rise_cyc = cyc;
        wait_prev = bus.oWait;
        if (bus.oIC_done || bus.oDC_done) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_done: ic=%b dc=%b with no request outstanding", bus.oIC_done, bus.oDC_done);
            end else begin
                e = exp_q.pop_front();
                chk("done_src", {31'b0, bus.oDC_done}, {31'b0, e.src});
                chk("one_done", {31'b0, bus.oIC_done & bus.oDC_done}, 32'd0);
                if (e.chk_dt) chk("done_dt", e.src ? bus.oDC_dt : bus.oIC_dt, e.dt);
                chk("latency", cyc - rise_cyc, e.lat);
                chk("wait_at_done", {30'b0, bus.oWait}, 32'd3);
            end
        end
        if (bus.mem_wr) begin
            if (wr_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_write: addr %h byte %h with none expected", bus.mem_a, bus.mem_dout);
            end else begin
                w = wr_q.pop_front();
                chk("wr_addr", bus.mem_a, w.a);
                chk("wr_byte", {24'b0, bus.mem_dout}, {24'b0, w.b});
            end
        end
    end

    task automatic dc_req(input logic ls, input logic [31:0] pc, input logic [31:0] dt, input logic [2:0] len);
        logic got = 1'b0;
        bus.iDC_ls = ls; bus.iDC_pc = pc; bus.iDC_dt = dt; bus.iDC_len = len; bus.iDC_en = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (bus.oDC_done) got = 1'b1;
        end
        bus.iDC_en = 1'b0;
        chk("dc_done_seen", {31'b0, got}, 32'd1);
    endtask

    task automatic ic_req(input logic [31:0] pc);
        logic got = 1'b0;
        bus.iIC_pc = pc; bus.iIC_en = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (bus.oIC_done) got = 1'b1;
        end
        bus.iIC_en = 1'b0;
        chk("ic_done_seen", {31'b0, got}, 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rdy = 1'b1;
        bus.iIC_en = 1'b0; bus.iIC_pc = '0;
        bus.iDC_en = 1'b0; bus.iDC_ls = 1'b0; bus.iDC_pc = '0; bus.iDC_dt = '0; bus.iDC_len = '0;
        bus.io_buffer_full = 1'b0;
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        ram[16'h0100] = 8'h13; ram[16'h0101] = 8'h05;
        ram[16'h0200] = 8'hAA; ram[16'h0201] = 8'hBB;
        ram[16'h0300] = 8'h11; ram[16'h0301] = 8'h22; ram[16'h0302] = 8'h33; ram[16'h0303] = 8'h44;
        ram[16'hFFFF] = 8'h77; ram[16'h0000] = 8'h66;

        #12;
        chk("rst_ic_done", {31'b0, bus.oIC_done}, 32'd0);
        chk("rst_dc_done", {31'b0, bus.oDC_done}, 32'd0);
        chk("rst_ic_dt", bus.oIC_dt, 32'd0);
        chk("rst_dc_dt", bus.oDC_dt, 32'd0);
        chk("rst_mem_a", bus.mem_a, 32'd0);
        chk("rst_mem_dout", {24'b0, bus.mem_dout}, 32'd0);
        chk("rst_mem_wr", {31'b0, bus.mem_wr}, 32'd0);
        chk("rst_wait", {30'b0, bus.oWait}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        idle(2);

        // Plain fetch.
        exp_done(SRC_IC, 1'b1, 32'h0000_0513, 5);
        ic_req(32'h0000_0100);
        idle(2);
        chk("wait_idle", {30'b0, bus.oWait}, 32'd0);

        // Simultaneous requests: dcache first, fetch right after.
        exp_done(SRC_DC, 1'b1, 32'h0000_BBAA, 3);
        exp_done(SRC_IC, 1'b1, 32'h0000_0513, 5);
        fork
            dc_req(1'b0, 32'h0000_0200, 32'h0, 3'd2);
            ic_req(32'h0000_0100);
        join
        idle(2);

        // Word store then read back with illegal lengths 3 and 0.
        exp_wr(32'h1000, 8'hEF); exp_wr(32'h1001, 8'hBE); exp_wr(32'h1002, 8'hAD); exp_wr(32'h1003, 8'hDE);
        exp_done(SRC_DC, 1'b0, 32'h0, 4);
        dc_req(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 3'd4);
        idle(2);
        exp_done(SRC_DC, 1'b1, 32'hDEAD_BEEF, 5);
        dc_req(1'b0, 32'h0000_1000, 32'h0, 3'd3);
        idle(2);
        exp_done(SRC_DC, 1'b1, 32'hDEAD_BEEF, 5);
        dc_req(1'b0, 32'h0000_1000, 32'h0, 3'd0);
        idle(2);

        // Address wrap at the top of the space.
        exp_done(SRC_DC, 1'b1, 32'h0000_6677, 3);
        dc_req(1'b0, 32'hFFFF_FFFF, 32'h0, 3'd2);
        idle(2);

        // IO store stalled by a full buffer.
        bus.io_buffer_full = 1'b1;
        exp_wr(32'h0003_0000, 8'h5A);
        exp_done(SRC_DC, 1'b0, 32'h0, 3);
        fork
            dc_req(1'b1, 32'h0003_0000, 32'h0000_005A, 3'd1);
            begin
                @(posedge clk); @(posedge clk); @(posedge clk);
                #1 bus.io_buffer_full = 1'b0;
            end
        join
        idle(2);

        // Full buffer must not stall a non-IO store.
        bus.io_buffer_full = 1'b1;
        exp_wr(32'h1100, 8'h34); exp_wr(32'h1101, 8'h12);
        exp_done(SRC_DC, 1'b0, 32'h0, 2);
        dc_req(1'b1, 32'h0000_1100, 32'h0000_1234, 3'd2);
        bus.io_buffer_full = 1'b0;
        idle(2);

        // rdy low for 2 cycles mid-read.
        exp_done(SRC_DC, 1'b1, 32'h4433_2211, 7);
        fork
            dc_req(1'b0, 32'h0000_0300, 32'h0, 3'd4);
            begin
                @(posedge clk); @(posedge clk);
                #1 rdy = 1'b0;
                @(posedge clk); @(posedge clk);
                #1 rdy = 1'b1;
            end
        join
        idle(2);

        // rdy low during a store must not repeat the write.
        exp_wr(32'h1200, 8'hFE); exp_wr(32'h1201, 8'hCA);
        exp_done(SRC_DC, 1'b0, 32'h0, 3);
        fork
            dc_req(1'b1, 32'h0000_1200, 32'h0000_CAFE, 3'd2);
            begin
                @(posedge clk);
                #1 rdy = 1'b0;
                @(posedge clk);
                #1 rdy = 1'b1;
            end
        join
        idle(2);

        // Reset in the middle of a word store.
        exp_wr(32'h2000, 8'hEF); exp_wr(32'h2001, 8'hBE);
        bus.iDC_ls = 1'b1; bus.iDC_pc = 32'h0000_2000; bus.iDC_dt = 32'hDEAD_BEEF; bus.iDC_len = 3'd4;
        bus.iDC_en = 1'b1;
        @(posedge clk); @(posedge clk); @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("arst_mem_wr", {31'b0, bus.mem_wr}, 32'd0);
        chk("arst_wait", {30'b0, bus.oWait}, 32'd0);
        chk("arst_mem_a", bus.mem_a, 32'd0);
        chk("arst_mem_dout", {24'b0, bus.mem_dout}, 32'd0);
        chk("arst_dc_done", {31'b0, bus.oDC_done}, 32'd0);
        chk("arst_dc_dt", bus.oDC_dt, 32'd0);
        bus.iDC_en = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        idle(2);
        exp_done(SRC_DC, 1'b1, 32'h0000_BEEF, 3);
        dc_req(1'b0, 32'h0000_1000, 32'h0, 3'd2);
        idle(3);

        chk("exp_q_empty", exp_q.size(), 32'd0);
        chk("wr_q_empty", wr_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
